pswd_verifier: RTL and testbench



---
 rtl/pswd_pkg.sv | 29 ++
 rtl/pswd_verifier_if.sv | 33 +++
 rtl/pswd_cycle_timer.sv | 47 ++++
 rtl/pswd_verifier.sv | 191 +++++++++++++++++++
 tb/tb_pswd_verifier.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pswd_pkg.sv
// -----------------------------------------------------------------------------
// pswd_pkg
// Shared types and constants for the password verifier slice.
//   state_e    : verifier FSM encoding
//   DIGIT_W    : width of one BCD digit
//   MAX_DIGIT  : largest legal BCD digit value
//   cnt_width(): bits needed to hold 0..max_val (at least 1)
//   ERR_W      : width of the consecutive-failure counter (covers MAX_ERR up to 7)
// -----------------------------------------------------------------------------
package pswd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMP,
        ST_RESULT,
        ST_UNLOCK,
        ST_ALARM
    } state_e;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] MAX_DIGIT = 4'd9;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int ERR_W = cnt_width(7);

endpackage

// File: rtl/pswd_verifier_if.sv
// -----------------------------------------------------------------------------
// pswd_verifier_if
// Request/result bundle between the entry register / lock FSM (master) and
// the password verifier (slave).
//   check_req, entered, stored, relock, admin_clr : master -> slave
//   check_busy, check_done, check_pass,
//   unlocked, alarm, err_count                   : slave -> master
// -----------------------------------------------------------------------------
interface pswd_verifier_if #(
    parameter int DIGITS = 4
);
    logic                                   check_req;
    logic [pswd_pkg::DIGIT_W*DIGITS-1:0]    entered;
    logic [pswd_pkg::DIGIT_W*DIGITS-1:0]    stored;
    logic                                   relock;
    logic                                   admin_clr;
    logic                                   check_busy;
    logic                                   check_done;
    logic                                   check_pass;
    logic                                   unlocked;
    logic                                   alarm;
    logic [pswd_pkg::ERR_W-1:0]             err_count;

    modport master (
        output check_req, entered, stored, relock, admin_clr,
        input  check_busy, check_done, check_pass, unlocked, alarm, err_count
    );

    modport slave (
        input  check_req, entered, stored, relock, admin_clr,
        output check_busy, check_done, check_pass, unlocked, alarm, err_count
    );
endinterface

// File: rtl/pswd_cycle_timer.sv
// -----------------------------------------------------------------------------
// pswd_cycle_timer
// Loadable down-counter used for the unlock window and the alarm timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load value with load_val (wins over run)
//   load_val   : value loaded
//   run        : count down while high; when low the counter is held at 0
//   value      : current count
//   expire     : high while value == 1 (last cycle of the window)
// -----------------------------------------------------------------------------
module pswd_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] value_d, value_q;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (!run) begin
            value_d = '0;
        end else if (value_q != '0) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value  = value_q;
    assign expire = (value_q == W'(1));

endmodule

// File: rtl/pswd_verifier.sv
// -----------------------------------------------------------------------------
// pswd_verifier
// Compares the entered BCD word with the stored password one digit per cycle
// (constant time), tracks consecutive failures, and drives the unlock window
// and alarm lockout.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pswd_verifier_if.slave (request inputs, status/result outputs)
// Optional build macro PSWD_ALARM_TIMEOUT_EN: alarm clears itself after
// ALARM_CYCLES cycles; otherwise only admin_clr or reset leave the alarm.
// -----------------------------------------------------------------------------
module pswd_verifier
    import pswd_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int MAX_ERR       = 3,
    parameter int UNLOCK_CYCLES = 20,
    parameter int ALARM_CYCLES  = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    pswd_verifier_if.slave   bus
);

    localparam int WORD_W  = DIGIT_W * DIGITS;
    localparam int IDX_W   = cnt_width(DIGITS - 1);
    localparam int TMR_MAX = (UNLOCK_CYCLES > ALARM_CYCLES) ? UNLOCK_CYCLES : ALARM_CYCLES;
    localparam int TMR_W   = cnt_width(TMR_MAX);

    localparam logic [ERR_W-1:0] ERR_LIMIT   = ERR_W'(MAX_ERR);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DIGITS - 1);
    localparam logic [TMR_W-1:0] UNLOCK_LOAD = TMR_W'(UNLOCK_CYCLES);
`ifdef PSWD_ALARM_TIMEOUT_EN
    localparam logic [TMR_W-1:0] ALARM_LOAD  = TMR_W'(ALARM_CYCLES);
`endif

    state_e              state_d, state_q;
    logic [WORD_W-1:0]   ent_d, ent_q;
    logic [WORD_W-1:0]   sto_d, sto_q;
    logic [IDX_W-1:0]    idx_d, idx_q;
    logic                mis_d, mis_q;
    logic [ERR_W-1:0]    err_d, err_q;
    logic                busy_d, busy_q;
    logic                done_d, done_q;
    logic                pass_d, pass_q;
    logic                unlocked_d, unlocked_q;
    logic                alarm_d, alarm_q;

    logic                tmr_load, tmr_run, tmr_expire;
    logic [TMR_W-1:0]    tmr_val;
    // Count value is for other timer users; this block only needs expiry.
    logic [TMR_W-1:0]    tmr_value_unused;

    logic [DIGIT_W-1:0]  ent_nib, sto_nib;

    assign ent_nib = ent_q[idx_q*DIGIT_W +: DIGIT_W];
    assign sto_nib = sto_q[idx_q*DIGIT_W +: DIGIT_W];

    pswd_cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .run      (tmr_run),
        .value    (tmr_value_unused),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        ent_d    = ent_q;
        sto_d    = sto_q;
        idx_d    = idx_q;
        mis_d    = mis_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_val  = UNLOCK_LOAD;
        tmr_run  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.admin_clr) begin
                    err_d = '0;
                end
                if (bus.check_req) begin
                    ent_d   = bus.entered;
                    sto_d   = bus.stored;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                // Every digit is visited regardless of earlier mismatches so
                // the check time does not leak where the first error is.
                // An entered digit > 9 is a mismatch, so an invalid stored
                // digit can never be matched either.
                mis_d = mis_q | (ent_nib != sto_nib) | (ent_nib > MAX_DIGIT);
                if (idx_q == IDX_LAST) begin
                    state_d = ST_RESULT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_RESULT: begin
                if (!mis_q) begin
                    err_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = UNLOCK_LOAD;
                    state_d  = ST_UNLOCK;
                end else begin
                    err_d = (err_q >= ERR_LIMIT) ? ERR_LIMIT : err_q + 1'b1;
                    if (err_d == ERR_LIMIT) begin
                        state_d = ST_ALARM;
`ifdef PSWD_ALARM_TIMEOUT_EN
                        tmr_load = 1'b1;
                        tmr_val  = ALARM_LOAD;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_UNLOCK: begin
                tmr_run = 1'b1;
                if (bus.admin_clr) begin
                    err_d = '0;
                end
                if (bus.relock || tmr_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALARM: begin
`ifdef PSWD_ALARM_TIMEOUT_EN
                tmr_run = 1'b1;
                if (bus.admin_clr || tmr_expire) begin
`else
                if (bus.admin_clr) begin
`endif
                    err_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d     = (state_d == ST_CMP);
        done_d     = (state_d == ST_RESULT);
        pass_d     = (state_d == ST_RESULT) && !mis_d;
        unlocked_d = (state_d == ST_UNLOCK);
        alarm_d    = (state_d == ST_ALARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ent_q      <= '0;
            sto_q      <= '0;
            idx_q      <= '0;
            mis_q      <= 1'b0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ent_q      <= ent_d;
            sto_q      <= sto_d;
            idx_q      <= idx_d;
            mis_q      <= mis_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
        end
    end

    assign bus.check_busy = busy_q;
    assign bus.check_done = done_q;
    assign bus.check_pass = pass_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.alarm      = alarm_q;
    assign bus.err_count  = err_q;

endmodule

// File: tb/tb_pswd_verifier.sv
// -----------------------------------------------------------------------------
// tb_pswd_verifier
// Directed bench for pswd_verifier. Expected check_pass values are queued when
// a request is issued and compared when check_done appears.
// Build with PSWD_ALARM_TIMEOUT_EN to exercise the alarm self-clear.
// -----------------------------------------------------------------------------
module tb_pswd_verifier;

    localparam int DIGITS        = 4;
    localparam int MAX_ERR       = 3;
    localparam int UNLOCK_CYCLES = 20;
    localparam int ALARM_CYCLES  = 10;

    logic clk;
    logic rst_n;

    pswd_verifier_if #(.DIGITS(DIGITS)) bus ();

    pswd_verifier #(
        .DIGITS        (DIGITS),
        .MAX_ERR       (MAX_ERR),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .ALARM_CYCLES  (ALARM_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic sb[$];
    logic exp_pass_mon;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.check_busy, bus.check_done, bus.check_pass,
                bus.unlocked, bus.alarm, bus.err_count};
    endfunction

    // Result monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.check_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_pass_mon = sb.pop_front();
                chk("check_pass", {31'd0, bus.check_pass}, {31'd0, exp_pass_mon});
            end
        end
    end

    // Counts negedges after the sampling edge until check_done is seen.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.check_done) break;
            n++;
        end
    endtask

    task automatic do_check(input logic [15:0] ent, input logic [15:0] sto,
                            input logic exp_pass, input logic clr, input logic exp_done);
        int n;
        @(negedge clk);
        bus.entered   = ent;
        bus.stored    = sto;
        bus.check_req = 1'b1;
        bus.admin_clr = clr;
        if (exp_done) sb.push_back(exp_pass);
        @(posedge clk);
        #1;
        bus.check_req = 1'b0;
        bus.admin_clr = 1'b0;
        bus.stored    = ~sto;   // must not influence the result
        if (exp_done) begin
            wait_done(n);
            chk("latency", n, DIGITS);
        end else begin
            repeat (DIGITS + 1) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.check_req = 1'b0;
        bus.entered   = '0;
        bus.stored    = '0;
        bus.relock    = 1'b0;
        bus.admin_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {24'd0, outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Correct password: pass, then a 20-cycle unlock window.
        do_check(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1);
        bus.entered = 16'h1235;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            bus.check_req = (n == 3);   // ignored inside the unlock window
            if (!bus.unlocked) break;
            n++;
        end
        bus.check_req = 1'b0;
        chk("unlock_len", n, UNLOCK_CYCLES);
        chk("err_after_pass", {29'd0, bus.err_count}, 32'd0);

        // Three consecutive failures lead to alarm.
        for (int k = 1; k <= MAX_ERR; k++) begin
            do_check(16'h1235, 16'h1234, 1'b0, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            chk("err_count_fail", {29'd0, bus.err_count}, k);
        end
        chk("alarm_set", {31'd0, bus.alarm}, 32'd1);

        // Request in alarm is ignored.
        do_check(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0);
        chk("alarm_hold_req", {31'd0, bus.alarm}, 32'd1);
        chk("err_hold_req", {29'd0, bus.err_count}, 32'd3);

        // Admin clear leaves alarm.
        @(negedge clk);
        bus.admin_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.admin_clr = 1'b0;
        chk("alarm_clr", {31'd0, bus.alarm}, 32'd0);
        chk("err_clr", {29'd0, bus.err_count}, 32'd0);

        // Invalid BCD digit never matches.
        do_check(16'h12A4, 16'h12A4, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("err_invalid", {29'd0, bus.err_count}, 32'd1);

        // admin_clr together with a failing request: clear, then count this failure.
        do_check(16'h1235, 16'h1234, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("err_clr_and_fail", {29'd0, bus.err_count}, 32'd1);

        // Pass, then relock in the fifth unlock cycle.
        do_check(16'h9876, 16'h9876, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("unlock_start", {31'd0, bus.unlocked}, 32'd1);
        chk("err_pass_reset", {29'd0, bus.err_count}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("unlock_cycle5", {31'd0, bus.unlocked}, 32'd1);
        bus.relock = 1'b1;
        @(posedge clk);
        #1;
        bus.relock = 1'b0;
        chk("relock_drop", {31'd0, bus.unlocked}, 32'd0);

        // Requests while comparing are ignored; only the first one answers.
        @(negedge clk);
        bus.entered   = 16'h4321;
        bus.stored    = 16'h4321;
        bus.check_req = 1'b1;
        sb.push_back(1'b1);
        @(posedge clk);
        #1;
        chk("busy_in_cmp", {31'd0, bus.check_busy}, 32'd1);
        bus.entered = 16'h1111;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.check_req = 1'b0;
        wait_done(n);
        chk("latency_after_ignored", n, DIGITS - 2);
        @(posedge clk);
        #1;
        bus.relock = 1'b1;
        @(posedge clk);
        #1;
        bus.relock = 1'b0;
        chk("relock_drop2", {31'd0, bus.unlocked}, 32'd0);

        // Reset in the middle of a comparison.
        do_check(16'h1235, 16'h1234, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus.entered   = 16'h1234;
        bus.stored    = 16'h1234;
        bus.check_req = 1'b1;
        @(posedge clk);
        #1;
        bus.check_req = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_cmp", {24'd0, outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DIGITS + 3) @(posedge clk);
        #1;
        chk("after_reset_idle", {24'd0, outs()}, 32'd0);

        // Alarm exit behaviour.
        for (int k = 1; k <= MAX_ERR; k++) begin
            do_check(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1);
        end
        n = 0;
`ifdef PSWD_ALARM_TIMEOUT_EN
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!bus.alarm) break;
            n++;
        end
        chk("alarm_timeout_len", n, ALARM_CYCLES);
        chk("alarm_timeout_err", {29'd0, bus.err_count}, 32'd0);
`else
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (!bus.alarm) break;
            n++;
        end
        chk("alarm_persist", n, 30);
        @(negedge clk);
        bus.admin_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.admin_clr = 1'b0;
        chk("alarm_clr2", {31'd0, bus.alarm}, 32'd0);
        chk("err_clr2", {29'd0, bus.err_count}, 32'd0);
`endif

        // Correct password works again after the alarm.
        do_check(16'h5555, 16'h5555, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("unlock_after_alarm", {31'd0, bus.unlocked}, 32'd1);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
